// File: rtl/monaco_pkg.sv
// rtl/monaco_pkg.sv - shared types, geometry constants and palettes for the track/car pixel path
package monaco_pkg;

  localparam int ACT_W = 320;
  localparam int ACT_H = 240;
  localparam int CAR_W = 16;
  localparam int CAR_H = 24;
  localparam logic [16:0] CAR_BASE = 17'd76800;

  typedef enum logic [1:0] {IDLE, BG, CAR} fetch_state_t;

  typedef logic [23:0] rgb_t;

  localparam rgb_t TRACK_PAL [8] = '{
    24'h1a1a1a, 24'h2e8b57, 24'h808080, 24'hc0c0c0,
    24'hffffff, 24'hd2b48c, 24'h3c3cff, 24'hff3c3c
  };

  // Entry 0 is the transparent index and is never displayed.
  localparam rgb_t CAR_PAL [8] = '{
    24'h000000, 24'hff0000, 24'hffd700, 24'h0050ff,
    24'h202020, 24'hf0f0f0, 24'h00c000, 24'hff8000
  };

  function automatic logic [16:0] track_addr(input logic [9:0] x, input logic [9:0] y);
    return 17'(y) * 17'(ACT_W) + 17'(x);
  endfunction

  function automatic logic [16:0] car_addr(input logic [9:0] dx, input logic [9:0] dy);
    return CAR_BASE + 17'(dy) * 17'(CAR_W) + 17'(dx);
  endfunction

endpackage

// File: rtl/monaco_palette_lut.sv
// rtl/monaco_palette_lut.sv - combinational palette lookup for track and car indices
module monaco_palette_lut
  import monaco_pkg::*;
(
  input  logic [3:0] pal_addr,
  output rgb_t       colour
);

  // pal_addr[3] selects the car palette, pal_addr[2:0] is the colour index.
  always_comb begin
    colour = pal_addr[3] ? CAR_PAL[pal_addr[2:0]] : TRACK_PAL[pal_addr[2:0]];
  end

endmodule

// File: rtl/track_sprite_fetch_sequencer.sv
// rtl/track_sprite_fetch_sequencer.sv - two-read-per-pixel ROM sequencer compositing the car over the track
module track_sprite_fetch_sequencer
  import monaco_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        pix_en,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  CarX,
  input  logic [9:0]  CarY,
  output logic [16:0] rom_addr,
  output logic        rom_rd,
  input  logic [2:0]  rom_data,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        pix_valid,
  output logic        overrun
);

  fetch_state_t state_q, state_d;
  logic [9:0]   px_q, px_d, py_q, py_d;
  logic [9:0]   car_xs_q, car_xs_d, car_ys_q, car_ys_d;
  logic [2:0]   bg_idx_q, bg_idx_d;
  logic         blk1_q, blk1_d, blk2_q, blk2_d;
  logic         miss_q, miss_d;
  rgb_t         rgb_q, rgb_d;
  logic         pix_valid_q, pix_valid_d;
  logic         overrun_q, overrun_d;

  logic         in_area;
  logic         hit;
  logic [2:0]   car_idx;
  logic [3:0]   pal_addr;
  rgb_t         pal_colour;

  // Area and car hit tests; the car window bounds are widened to 11 bits so they never wrap.
  always_comb begin
    in_area = (DrawX < 10'(ACT_W)) && (DrawY < 10'(ACT_H));
    hit     = ({1'b0, px_q} >= {1'b0, car_xs_q}) &&
              ({1'b0, px_q} <  ({1'b0, car_xs_q} + 11'(CAR_W))) &&
              ({1'b0, py_q} >= {1'b0, car_ys_q}) &&
              ({1'b0, py_q} <  ({1'b0, car_ys_q} + 11'(CAR_H)));
    car_idx  = (state_q == CAR) ? rom_data : 3'd0;
    pal_addr = (car_idx != 3'd0) ? {1'b1, car_idx} : {1'b0, bg_idx_q};
  end

  monaco_palette_lut u_palette (
    .pal_addr (pal_addr),
    .colour   (pal_colour)
  );

  // Fetch FSM, ROM request, delay-matching of black/no-car pixels and composite select.
  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    car_xs_d    = car_xs_q;
    car_ys_d    = car_ys_q;
    bg_idx_d    = bg_idx_q;
    blk1_d      = 1'b0;
    blk2_d      = blk1_q;
    miss_d      = 1'b0;
    rgb_d       = rgb_q;
    pix_valid_d = 1'b0;
    overrun_d   = overrun_q;
    rom_addr    = '0;
    rom_rd      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pix_en) begin
          px_d = DrawX;
          py_d = DrawY;
          if (DrawX == '0 && DrawY == '0) begin
            car_xs_d = CarX;
            car_ys_d = CarY;
          end
          if (in_area) begin
            rom_addr = track_addr(DrawX, DrawY);
            rom_rd   = 1'b1;
            state_d  = BG;
          end else begin
            blk1_d = 1'b1;
          end
        end
      end
      BG: begin
        bg_idx_d = rom_data;
        if (hit) begin
          rom_addr = car_addr(px_q - car_xs_q, py_q - car_ys_q);
          rom_rd   = 1'b1;
          state_d  = CAR;
        end else begin
          miss_d  = 1'b1;
          state_d = IDLE;
        end
        if (pix_en) overrun_d = 1'b1;
      end
      CAR: begin
        state_d = IDLE;
        if (pix_en) overrun_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Every pixel type lands here on the same cycle relative to its pix_en.
    if (blk2_q) begin
      rgb_d       = '0;
      pix_valid_d = 1'b1;
    end else if (miss_q || state_q == CAR) begin
      rgb_d       = pal_colour;
      pix_valid_d = 1'b1;
    end

    if (Reset) begin
      rom_addr = '0;
      rom_rd   = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      px_q        <= '0;
      py_q        <= '0;
      car_xs_q    <= '0;
      car_ys_q    <= '0;
      bg_idx_q    <= '0;
      blk1_q      <= 1'b0;
      blk2_q      <= 1'b0;
      miss_q      <= 1'b0;
      rgb_q       <= '0;
      pix_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      car_xs_q    <= car_xs_d;
      car_ys_q    <= car_ys_d;
      bg_idx_q    <= bg_idx_d;
      blk1_q      <= blk1_d;
      blk2_q      <= blk2_d;
      miss_q      <= miss_d;
      rgb_q       <= rgb_d;
      pix_valid_q <= pix_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign Red       = rgb_q[23:16];
  assign Green     = rgb_q[15:8];
  assign Blue      = rgb_q[7:0];
  assign pix_valid = pix_valid_q;
  assign overrun   = overrun_q;

endmodule
